// File: rtl/alu_pkg.sv
// Shared ALU issue definitions: unit selects, sub-op codes,
// RV32I opcodes and the decoded bundle handed to the ALU.
package alu_pkg;

   localparam int DATA_W = 32;

   localparam logic [2:0] OP_SEL_NONE = 3'b000;
   localparam logic [2:0] OP_SEL_ADD  = 3'b001;
   localparam logic [2:0] OP_SEL_CMP  = 3'b010;
   localparam logic [2:0] OP_SEL_BOOL = 3'b100;

   localparam logic [1:0] BOOL_XOR     = 2'b00;
   localparam logic [1:0] BOOL_OR      = 2'b10;
   localparam logic [1:0] BOOL_AND     = 2'b11;
   localparam logic [1:0] CMP_SIGNED   = 2'b00;
   localparam logic [1:0] CMP_UNSIGNED = 2'b01;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

   typedef struct packed {
      logic [DATA_W-1:0] op_a;
      logic [DATA_W-1:0] op_b;
      logic              sub;
      logic [1:0]        bool_op;
      logic [2:0]        op_sel;
      logic [4:0]        rd;
      logic              rd_we;
      logic              illegal;
   } alu_bundle_t;

endpackage

// File: rtl/alu_issue_decode.sv
// Combinational RV32I integer-ALU decoder: instruction word,
// PC and register data in, ALU control bundle out.
module alu_issue_decode
   import alu_pkg::*;
(
   input  logic [31:0]       insn,
   input  logic [DATA_W-1:0] pc,
   input  logic [DATA_W-1:0] rs1_data,
   input  logic [DATA_W-1:0] rs2_data,
   output alu_bundle_t       bundle
);

   logic [6:0]        opcode;
   logic [2:0]        funct3;
   logic [6:0]        funct7;
   logic [4:0]        rd;
   logic [DATA_W-1:0] imm_i;
   logic [DATA_W-1:0] imm_u;

   assign opcode = insn[6:0];
   assign rd     = insn[11:7];
   assign funct3 = insn[14:12];
   assign funct7 = insn[31:25];
   assign imm_i  = {{20{insn[31]}}, insn[31:20]};
   assign imm_u  = {insn[31:12], 12'b0};

   // Decode opcode/funct fields; anything unsupported becomes an inert illegal bundle
   always_comb begin
      logic              legal;
      logic              is_op;
      logic              f7_ok;
      logic              sub;
      logic [1:0]        bop;
      logic [2:0]        sel;
      logic [DATA_W-1:0] a;
      logic [DATA_W-1:0] b;
      legal = 1'b0;
      sub   = 1'b0;
      bop   = 2'b00;
      sel   = OP_SEL_NONE;
      a     = '0;
      b     = '0;
      is_op = (opcode == OPC_OP);
      f7_ok = (funct7 == 7'b0000000) ||
              (funct7 == 7'b0100000 && funct3 == 3'b000);
      bundle = '0;
      if (is_op || opcode == OPC_OP_IMM) begin
         legal = !is_op || f7_ok;
         a     = rs1_data;
         b     = is_op ? rs2_data : imm_i;
         case (funct3)
            3'b000: begin
               sel = OP_SEL_ADD;
               sub = is_op & funct7[5];
            end
            3'b010: begin
               sel = OP_SEL_CMP;
               bop = CMP_SIGNED;
               sub = 1'b1;
            end
            3'b011: begin
               sel = OP_SEL_CMP;
               bop = CMP_UNSIGNED;
               sub = 1'b1;
            end
            3'b100: begin
               sel = OP_SEL_BOOL;
               bop = BOOL_XOR;
            end
            3'b110: begin
               sel = OP_SEL_BOOL;
               bop = BOOL_OR;
            end
            3'b111: begin
               sel = OP_SEL_BOOL;
               bop = BOOL_AND;
            end
            default: legal = 1'b0;
         endcase
      end else if (opcode == OPC_LUI || opcode == OPC_AUIPC) begin
         legal = 1'b1;
         sel   = OP_SEL_ADD;
         a     = (opcode == OPC_AUIPC) ? pc : '0;
         b     = imm_u;
      end
      bundle.rd      = rd;
      bundle.illegal = !legal;
      bundle.rd_we   = legal && (rd != 5'd0);
      if (legal) begin
         bundle.op_a    = a;
         bundle.op_b    = b;
         bundle.sub     = sub;
         bundle.bool_op = bop;
         bundle.op_sel  = sel;
      end
   end

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: decode plus output register and skid register.
// Define ALU_ISSUE_FWD_EN to add the writeback bypass ports.
module alu_issue_stage
   import alu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_valid,
   output logic            o_ready,
   input  logic [31:0]     i_insn,
   input  logic [XLEN-1:0] i_pc,
   input  logic [XLEN-1:0] i_rs1_data,
   input  logic [XLEN-1:0] i_rs2_data,
   input  logic            i_flush,
   output logic            o_valid,
   input  logic            i_ready,
`ifdef ALU_ISSUE_FWD_EN
   input  logic            i_wb_we,
   input  logic [4:0]      i_wb_rd,
   input  logic [XLEN-1:0] i_wb_data,
`endif
   output logic [XLEN-1:0] o_op_a,
   output logic [XLEN-1:0] o_op_b,
   output logic            o_sub,
   output logic [1:0]      o_bool_op,
   output logic [2:0]      o_op_sel,
   output logic [4:0]      o_rd,
   output logic            o_rd_we,
   output logic            o_illegal
);

   logic [XLEN-1:0] rs1_val;
   logic [XLEN-1:0] rs2_val;
   alu_bundle_t     dec;
   alu_bundle_t     out_q;
   alu_bundle_t     skid_q;
   logic            out_valid;
   logic            skid_valid;
   logic            accept;

`ifdef ALU_ISSUE_FWD_EN
   // Bypass the writeback value over stale register-file data
   always_comb begin
      logic [4:0] rs1;
      logic [4:0] rs2;
      rs1     = i_insn[19:15];
      rs2     = i_insn[24:20];
      rs1_val = i_rs1_data;
      rs2_val = i_rs2_data;
      if (i_wb_we && i_wb_rd != 5'd0 && i_wb_rd == rs1)
         rs1_val = i_wb_data;
      if (i_wb_we && i_wb_rd != 5'd0 && i_wb_rd == rs2)
         rs2_val = i_wb_data;
   end
`else
   assign rs1_val = i_rs1_data;
   assign rs2_val = i_rs2_data;
`endif

   alu_issue_decode u_dec (
      .insn     (i_insn),
      .pc       (i_pc),
      .rs1_data (rs1_val),
      .rs2_data (rs2_val),
      .bundle   (dec)
   );

   assign accept  = i_valid && !skid_valid;
   assign o_ready = !skid_valid;

   // Output register refills from skid first so ordering is kept
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         out_q      <= '0;
         skid_q     <= '0;
         out_valid  <= 1'b0;
         skid_valid <= 1'b0;
      end else if (i_flush) begin
         out_valid  <= 1'b0;
         skid_valid <= 1'b0;
      end else if (!out_valid || i_ready) begin
         if (skid_valid) begin
            out_q      <= skid_q;
            out_valid  <= 1'b1;
            skid_valid <= 1'b0;
         end else begin
            out_valid <= accept;
            if (accept)
               out_q <= dec;
         end
      end else if (accept) begin
         skid_q     <= dec;
         skid_valid <= 1'b1;
      end
   end

   assign o_valid   = out_valid;
   assign o_op_a    = out_q.op_a;
   assign o_op_b    = out_q.op_b;
   assign o_sub     = out_q.sub;
   assign o_bool_op = out_q.bool_op;
   assign o_op_sel  = out_q.op_sel;
   assign o_rd      = out_q.rd;
   assign o_rd_we   = out_q.rd_we;
   assign o_illegal = out_q.illegal;

endmodule
